// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes bitstream words MSB-first onto the ccff chain, counting to CHAIN_LEN.
// Optional tail readback capture is enabled by defining CCFF_READBACK_EN.
module ccff_chain_loader #(
  parameter  int WORD_W    = 32,
  parameter  int CHAIN_LEN = 1024,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
`ifdef CCFF_READBACK_EN
  ,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data,
  input  logic              rb_ready,
  output logic              rb_ovf
`endif
);
  localparam int REM_W = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t             r_state, w_next;
  logic [WORD_W-1:0]  r_sreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [REM_W-1:0]   r_rem;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_left;
  logic [REM_W-1:0]   w_rem_ld;
  logic               w_last;
  logic               w_start;
  logic               w_accept;
  logic               w_shift;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_left    = CNT_W'(CHAIN_LEN) - r_cnt;
  assign w_rem_ld  = (32'(w_left) < WORD_W) ? REM_W'(w_left) : REM_W'(WORD_W);
  assign w_last    = w_cnt_inc == CNT_W'(CHAIN_LEN);
  assign w_start   = r_state == IDLE && start && !abort;
  assign w_accept  = r_state == FETCH && s_valid && !abort;
  // An aborted shift cycle is not counted, so bit_cnt freezes at its pre-abort value.
  assign w_shift   = r_state == SHIFT && !abort;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? FETCH : IDLE;
      FETCH:   w_next = s_valid ? SHIFT : FETCH;
      SHIFT:   w_next = w_last ? DONE : (r_rem == REM_W'(1) ? FETCH : SHIFT);
      default: w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) r_cnt <= '0;
      if (w_accept) begin
        r_sreg <= s_data;
        r_rem  <= w_rem_ld;
      end
      if (w_shift) begin
        r_sreg <= {r_sreg[WORD_W-2:0], 1'b0};
        r_cnt  <= w_cnt_inc;
        r_rem  <= r_rem - 1'b1;
      end
    end
  assign s_ready       = r_state == FETCH;
  assign ccff_shift_en = r_state == SHIFT;
  assign ccff_head     = r_state == SHIFT && r_sreg[WORD_W-1];
  assign busy          = r_state != IDLE;
  assign done          = r_state == DONE;
  assign bit_cnt       = r_cnt;
`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] r_cap;
  logic [REM_W-1:0]  r_ccnt;
  logic [WORD_W-1:0] w_cap_next;
  logic              w_word;
  assign w_cap_next = {r_cap[WORD_W-2:0], ccff_tail};
  // Capture restarts at zero after each word, so a short final word lands right-aligned.
  assign w_word     = w_shift && (r_ccnt == REM_W'(WORD_W - 1) || w_last);
  always_ff @(posedge prog_clk or negedge pReset_n)
    if (!pReset_n) begin
      r_cap    <= '0;
      r_ccnt   <= '0;
      rb_valid <= 1'b0;
      rb_data  <= '0;
      rb_ovf   <= 1'b0;
    end else begin
      if (w_start) begin
        r_cap  <= '0;
        r_ccnt <= '0;
        rb_ovf <= 1'b0;
      end else if (w_shift) begin
        r_cap  <= w_word ? '0 : w_cap_next;
        r_ccnt <= w_word ? '0 : r_ccnt + 1'b1;
      end
      if (w_word) begin
        rb_data  <= w_cap_next;
        rb_valid <= 1'b1;
        rb_ovf   <= rb_ovf | (rb_valid & ~rb_ready);
      end else if (rb_valid && rb_ready) begin
        rb_valid <= 1'b0;
      end
    end
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain driver: accepts bitstream words over a valid/ready stream and serializes them MSB-first onto the fabric configuration flip-flop chain (ccff_head) with a per-bit shift enable.
- Sits between the bitstream source (SoC/JTAG bridge) and the fabric's ccff_head/ccff_tail chain ends, in the programming clock domain.
- Counts bits to an exact chain length and signals completion.

Parameters:
WORD_W, 32, bitstream word width (>=2)
CHAIN_LEN, 1024, total ccff bits in the chain (>=1)
CNT_W, $clog2(CHAIN_LEN+1), derived; bit counter width

Ports:
prog_clk  input  1  programming clock; all state on rising edge
pReset_n  input  1  asynchronous active-low reset
start  input  1  begin a load (sampled in IDLE only)
abort  input  1  synchronous abort, any state
s_valid  input  1  bitstream word valid
s_data  input  WORD_W  bitstream word, bit WORD_W-1 shifted first
s_ready  output  1  word accepted when s_valid & s_ready
ccff_head  output  1  serial data into chain head
ccff_shift_en  output  1  chain flops capture ccff_head on prog_clk edge while high
ccff_tail  input  1  serial data from chain tail
busy  output  1  high in FETCH/SHIFT/DONE
done  output  1  one-cycle pulse at load completion
bit_cnt  output  CNT_W  bits shifted in current/last load

Behaviour:
- Reset (pReset_n=0, async): state=IDLE; s_ready, ccff_head, ccff_shift_en, busy, done = 0; bit_cnt=0; shift reg=0.
- All outputs decoded from registers only; no input-to-output combinational path.
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE: s_ready=0. start=1 -> FETCH; bit_cnt<=0.
- FETCH: s_ready=1. On s_valid&s_ready: shift reg<=s_data; remaining<=min(WORD_W, CHAIN_LEN-bit_cnt); -> SHIFT. s_valid low: stay, ccff_shift_en=0.
- SHIFT: s_ready=0; ccff_shift_en=1; ccff_head=shift reg MSB.
  - Each cycle: shift reg left by 1, bit_cnt+1, remaining-1.
  - Last bit (bit_cnt+1==CHAIN_LEN) -> DONE.
  - Else word exhausted (remaining==1) -> FETCH.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- Throughput: WORD_W+1 cycles per word minimum (one FETCH cycle per word).
- Partial final word: when CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the last word are shifted; the low bits are discarded.
- Exact bit count: exactly CHAIN_LEN cycles with ccff_shift_en=1 per completed load, never more.
- abort=1: next state IDLE from any state; ccff_shift_en=0 next cycle; no done; bit_cnt holds its value until the next start.
- abort and start together in IDLE: abort wins, stay IDLE.
- start while busy: ignored.
- Words offered in IDLE/DONE: not accepted (s_ready=0).
- Reset mid-load: immediate return to reset values; the partial chain contents are not the block's concern.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- Defined: adds ports rb_valid (output, 1), rb_data (output, WORD_W), rb_ready (input, 1), rb_ovf (output, 1).
  - Each SHIFT cycle samples ccff_tail into a capture reg (shift left, LSB in).
  - After WORD_W samples, or at the final bit of a load, rb_data<=capture and rb_valid<=1. A partial final word is right-aligned with upper bits zero.
  - rb_valid clears on rb_valid&rb_ready.
  - If a new word completes while rb_valid=1 and rb_ready=0: the word is overwritten and rb_ovf is set.
  - rb_ovf is sticky; it clears on start or reset.
  - rb_* reset to 0.
- Not defined: rb_* ports absent; ccff_tail ignored; no capture logic.

Test Plan:
- Reset: hold pReset_n=0 mid-clock -> all outputs 0 immediately; release, 10 idle cycles -> ccff_shift_en stays 0.
- Full load (CHAIN_LEN=40, WORD_W=32): start, words 0xA5A5A5A5 then 0xF00000FF, s_valid always high.
  - ccff_head sequence 10100101 x4 then 11110000.
  - Exactly 40 shift_en cycles; done pulses once; bit_cnt=40.
- Stall: s_valid low 5 cycles before word 2 -> FETCH held, ccff_shift_en=0 for those 5 cycles; bit stream identical to the previous test.
- Abort at bit_cnt=10 -> ccff_shift_en=0 next cycle, busy=0, no done, bit_cnt=10.
  - New start -> bit_cnt=0, full 40-bit load completes normally.
  - start pulsed during SHIFT -> no effect.
- CCFF_READBACK_EN: loop ccff_tail from a 40-stage chain model preloaded with 0x12345678_9A, rb_ready high.
  - rb_data=0x12345678 then 0x0000009A.
  - Repeat with rb_ready low -> rb_ovf=1 after the second word.
